// File: rtl/maindec_pkg.sv
// Shared opcodes, encodings and control bundle
// for the registered LEGv8 main decoder.
package maindec_pkg;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_ERET = 11'b11010110100;

  localparam logic [10:0] OP_CBZ   = 11'b10110100000;
  localparam logic [10:0] MASK_CBZ = 11'b11111111000;
  localparam logic [10:0] OP_ADDI  = 11'b10010001000;
  localparam logic [10:0] OP_SUBI  = 11'b11010001000;
  localparam logic [10:0] MASK_IMM = 11'b11111111110;
  localparam logic [10:0] OP_B     = 11'b00010100000;
  localparam logic [10:0] MASK_B   = 11'b11111100000;

  localparam logic [3:0] CAUSE_NONE      = 4'd0;
  localparam logic [3:0] CAUSE_UNDEF     = 4'd2;
  localparam logic [3:0] CAUSE_ERET_USER = 4'd3;
  localparam logic [3:0] CAUSE_DFAULT    = 4'd15;

  localparam logic [1:0] SRC_REG = 2'b00;
  localparam logic [1:0] SRC_DT  = 2'b01;
  localparam logic [1:0] SRC_IMM = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_PASSB = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;
  localparam logic [1:0] ALU_IMM   = 2'b11;

  typedef enum logic {
    USER    = 1'b0,
    HANDLER = 1'b1
  } mode_t;

  typedef struct packed {
    logic [1:0] alusrc;
    logic       reg2loc;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic       uncondbranch;
    logic [1:0] aluop;
  } ctrl_t;

  function automatic logic opmatch(
    input logic [10:0] op,
    input logic [10:0] val,
    input logic [10:0] mask
  );
    return (op & mask) == (val & mask);
  endfunction

endpackage

// File: rtl/maindec_comb.sv
// Combinational opcode decode: controls,
// defined flag and ERET detect.
import maindec_pkg::*;

module maindec_comb #(
  parameter bit EN_IMM = 1'b1,
  parameter bit EN_B   = 1'b1
) (
  input  logic [10:0] op,
  output ctrl_t       ctrl,
  output logic        defined,
  output logic        is_eret
);

  logic known;
  logic r_t, ldur, stur, cbz;
  logic imm, br, eret;

  // any unknown bit poisons every match
  assign known = !$isunknown(op);
  assign r_t   = known & ((op == OP_ADD)
               | (op == OP_SUB)
               | (op == OP_AND)
               | (op == OP_ORR));
  assign ldur  = known & (op == OP_LDUR);
  assign stur  = known & (op == OP_STUR);
  assign eret  = known & (op == OP_ERET);
  assign cbz   = known
               & opmatch(op, OP_CBZ, MASK_CBZ);
  assign imm   = known & EN_IMM
               & (opmatch(op, OP_ADDI, MASK_IMM)
               | opmatch(op, OP_SUBI, MASK_IMM));
  assign br    = known & EN_B
               & opmatch(op, OP_B, MASK_B);

  // one-hot opcode table to control bundle
  always_comb begin
    ctrl    = '0;
    defined = 1'b1;
    is_eret = 1'b0;
    unique case (1'b1)
      r_t: begin
        ctrl.regwrite = 1'b1;
        ctrl.aluop    = ALU_RTYPE;
      end
      ldur: begin
        ctrl.alusrc   = SRC_DT;
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.memread  = 1'b1;
        ctrl.aluop    = ALU_ADD;
      end
      stur: begin
        ctrl.reg2loc  = 1'b1;
        ctrl.alusrc   = SRC_DT;
        ctrl.memwrite = 1'b1;
        ctrl.aluop    = ALU_ADD;
      end
      cbz: begin
        ctrl.reg2loc = 1'b1;
        ctrl.branch  = 1'b1;
        ctrl.aluop   = ALU_PASSB;
      end
      imm: begin
        ctrl.alusrc   = SRC_IMM;
        ctrl.regwrite = 1'b1;
        ctrl.aluop    = ALU_IMM;
      end
      br: begin
        ctrl.uncondbranch = 1'b1;
        ctrl.aluop        = ALU_ADD;
      end
      eret: is_eret = 1'b1;
      default: defined = 1'b0;
    endcase
  end

endmodule

// File: rtl/maindec_exc_pipe.sv
// Registered main decoder with undefined-op
// detection and USER/HANDLER mode tracking.
import maindec_pkg::*;

module maindec_exc_pipe #(
  parameter bit EN_IMM  = 1'b1,
  parameter bit EN_B    = 1'b1,
  parameter int CAUSE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic               stall,
  input  logic               flush,
  input  logic [10:0]        Op,
  output logic               out_valid,
  output logic [1:0]         ALUSrc,
  output logic               Reg2Loc,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               Branch,
  output logic               UncondBranch,
  output logic [1:0]         ALUOp,
  output logic               ERet,
  output logic               Exc,
  output logic [CAUSE_W-1:0] ExcCause,
  output logic               mode
);

  ctrl_t              dec_ctrl, ctrl_n, ctrl_q;
  logic               defined, is_eret;
  logic               eret_n, exc_n;
  logic               valid_q, eret_q, exc_q;
  logic [CAUSE_W-1:0] cause_n, cause_q;
  mode_t              mode_n, mode_q;

  maindec_comb #(
    .EN_IMM (EN_IMM),
    .EN_B   (EN_B)
  ) u_dec (
    .op      (Op),
    .ctrl    (dec_ctrl),
    .defined (defined),
    .is_eret (is_eret)
  );

  // mode transition, exception raise and masking
  always_comb begin
    ctrl_n  = dec_ctrl;
    eret_n  = 1'b0;
    exc_n   = 1'b0;
    cause_n = CAUSE_W'(CAUSE_NONE);
    mode_n  = mode_q;
    unique case (1'b1)
      !defined: begin
        exc_n   = 1'b1;
        cause_n = (mode_q == HANDLER)
                ? CAUSE_W'(CAUSE_DFAULT)
                : CAUSE_W'(CAUSE_UNDEF);
        mode_n  = HANDLER;
      end
      is_eret && (mode_q == USER): begin
        exc_n   = 1'b1;
        cause_n = CAUSE_W'(CAUSE_ERET_USER);
        mode_n  = HANDLER;
      end
      is_eret && (mode_q == HANDLER): begin
        eret_n = 1'b1;
        mode_n = USER;
      end
      default: ;
    endcase
    if (exc_n) ctrl_n = '0;
  end

  // pipeline register: flush > stall > accept
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      eret_q  <= 1'b0;
      exc_q   <= 1'b0;
      cause_q <= '0;
      mode_q  <= USER;
    end else if (flush || (!stall && !in_valid)) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      eret_q  <= 1'b0;
      exc_q   <= 1'b0;
      cause_q <= '0;
    end else if (!stall) begin
      valid_q <= 1'b1;
      ctrl_q  <= ctrl_n;
      eret_q  <= eret_n;
      exc_q   <= exc_n;
      cause_q <= cause_n;
      mode_q  <= mode_n;
    end
  end

  assign out_valid    = valid_q;
  assign ALUSrc       = ctrl_q.alusrc;
  assign Reg2Loc      = ctrl_q.reg2loc;
  assign MemtoReg     = ctrl_q.memtoreg;
  assign RegWrite     = ctrl_q.regwrite;
  assign MemRead      = ctrl_q.memread;
  assign MemWrite     = ctrl_q.memwrite;
  assign Branch       = ctrl_q.branch;
  assign UncondBranch = ctrl_q.uncondbranch;
  assign ALUOp        = ctrl_q.aluop;
  assign ERet         = eret_q;
  assign Exc          = exc_q;
  assign ExcCause     = cause_q;
  assign mode         = mode_q;

endmodule

// File: doc/maindec_exc_pipe.md
Name: maindec_exc_pipe

Overview:
- Registered successor to the single-cycle main decoder for the LEGv8 core with exceptions.
- Decodes the 11-bit opcode into datapath controls one cycle after acceptance, and detects undefined instructions.
- Tracks processor mode (USER/HANDLER) so ERET is legal only inside a handler.
- Sits at the IF/ID to ID/EX boundary; supports stall and flush from the hazard and exception logic.

Parameters:
- EN_IMM, 1, decode ADDI/SUBI (1001000100x / 1101000100x); 0 = those opcodes are undefined.
- EN_B, 1, decode B (000101xxxxx); 0 = undefined.
- CAUSE_W, 4, width of ExcCause; must be >= 4.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  Op is valid this cycle
- stall  in  1  hold all registered outputs and mode
- flush  in  1  kill the instruction being registered
- Op  in  11  instruction[31:21]
- out_valid  out  1  registered controls are valid
- ALUSrc  out  2  00 register, 01 data-transfer imm, 10 ALU imm
- Reg2Loc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, UncondBranch  out  1 each  datapath controls
- ALUOp  out  2  00 add, 01 pass-B/CBZ, 10 R-type funct, 11 immediate arith
- ERet  out  1  exception return
- Exc  out  1  synchronous exception raised by this instruction
- ExcCause  out  CAUSE_W  0 none, 2 undefined, 3 ERET in USER, 15 double fault
- mode  out  1  0 USER, 1 HANDLER

Behaviour:
- Reset (async, immediate): all outputs 0; mode = USER.
- Latency: controls for Op accepted at edge N are visible after edge N, one cycle.
- Priority per edge: flush > stall > accept.
- Flush: out_valid, all controls, ERet, Exc and ExcCause go to 0; mode unchanged, even if in_valid=1.
- Stall (no flush): every output and mode hold; Op is ignored. Upstream keeps Op stable.
- No flush, no stall, in_valid=0: out_valid=0, controls 0, mode holds.
- Accept: out_valid=1; controls decoded from Op per the opcode table:
  - R-type (ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000): RegWrite, ALUOp=10.
  - LDUR 11111000010: ALUSrc=01, MemtoReg, RegWrite, MemRead, ALUOp=00.
  - STUR 11111000000: Reg2Loc, ALUSrc=01, MemWrite, ALUOp=00.
  - CBZ 10110100xxx: Reg2Loc, Branch, ALUOp=01.
  - ADDI/SUBI (EN_IMM): ALUSrc=10, RegWrite, ALUOp=11.
  - B (EN_B): UncondBranch=1, ALUOp=00.
  - ERET 11010110100: see the mode state machine below.
  - Exact-match opcodes are compared with all 11 bits. Prefix opcodes ignore only their x bits.
  - No opcode matches more than one entry.
- Mode state machine, evaluated only on accept:
  - USER, valid non-ERET op: stay USER, Exc=0.
  - USER, undefined op: Exc=1, cause 2; mode becomes HANDLER at the same edge.
  - USER, ERET: Exc=1, cause 3, ERet=0; mode becomes HANDLER.
  - HANDLER, ERET: ERet=1, Exc=0; mode becomes USER.
  - HANDLER, undefined op: Exc=1, cause 15; stay HANDLER.
  - HANDLER, other valid op: normal decode; stay HANDLER.
- Whenever Exc=1: RegWrite, MemRead, MemWrite, Branch, UncondBranch and ERet are forced 0, and ALUSrc/ALUOp are 0.
- X or Z bits on Op when in_valid=1 are treated as undefined, never as a match.
- Reset asserted mid-stall or mid-flush: reset wins immediately.

Decomposition:
- Package maindec_pkg holds:
  - opcode constants and prefix masks;
  - cause codes (CAUSE_NONE, CAUSE_UNDEF, CAUSE_ERET_USER, CAUSE_DFAULT);
  - ALUSrc and ALUOp encodings;
  - mode_t enum;
  - packed ctrl_t struct bundling all controls.
- One sub-module, maindec_comb: purely combinational Op -> {ctrl_t, defined, is_eret}, parameterised by EN_IMM/EN_B.
- The top level holds the pipeline register, stall/flush priority, mode FSM and exception masking.

Test Plan:
- Reset, then accept LDUR 11111000010 -> next cycle out_valid=1, ALUSrc=01, MemtoReg=RegWrite=MemRead=1, ALUOp=00, Exc=0, mode=0.
- USER accepts 11111111111 -> Exc=1, ExcCause=2, RegWrite=MemWrite=0, mode=1. Then accept ERET -> ERet=1, mode=0.
- USER accepts ERET 11010110100 -> Exc=1, ExcCause=3, ERet=0, mode=1. Then in HANDLER accept undefined 00000000000 -> ExcCause=15, mode stays 1.
- Accept ADD, then stall=1 for 3 cycles while Op changes to STUR -> outputs stay ADD (RegWrite=1, ALUOp=10) throughout. Stall+flush together -> all 0.
- Flush=1 with in_valid=1 and an undefined Op in USER -> out_valid=0, Exc=0, mode stays 0.
- EN_IMM=0, EN_B=0 build: ADDI 10010001000 -> ExcCause=2. EN_IMM=1: same Op -> ALUSrc=10, ALUOp=11, RegWrite=1. Async reset pulse mid-cycle -> outputs 0 before the next edge.
